// File: rtl/expander_pkg.sv
// Shared definitions for the expander and the capture-side compactor:
// width helpers and the config state encoding.
package expander_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // One pipeline layer per bit of the largest possible shift distance.
  function automatic int dl_of(input int dw);
    return clog2(dw);
  endfunction

  localparam int DEF_DW = 32;
  localparam int DEF_DL = dl_of(DEF_DW);
  localparam int DIST_W = DEF_DL;

  typedef enum logic [0:0] {
    CFG = 1'b0,
    RUN = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/expander_if.sv
// Stream bus: a word moves on every rising clock edge where valid and ready
// are both high; the master holds valid and data stable until that edge.
interface expander_if #(
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/expander_layer.sv
// One stage of the deposit network: each bit either keeps its position or
// takes the bit SHIFT places below it, as chosen by sel_i.
module expander_layer #(
  parameter int DW    = 32,
  parameter int SHIFT = 1
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  input  logic [DW-1:0] sel_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o
);
  logic [DW-1:0] shifted;
  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;
  logic          valid_q;

  assign shifted = data_i << SHIFT;
  assign data_d  = (shifted & sel_i) | (data_i & ~sel_i);

  always_ff @(posedge clk) begin
    if (clr_i) valid_q <= 1'b0;
    else if (adv_i) valid_q <= valid_i;
  end

  // Data travels with or without a valid word; bubbles move like words.
  always_ff @(posedge clk) begin
    if (adv_i) data_q <= data_d;
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/expander.sv
// Stream bit-expander (parallel bit deposit): scatters the low packed bits of
// each input word into the positions set in the latched mask.
module expander
  import expander_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctl_clr_i,
  input  logic          ctl_ena_i,
  input  logic [DW-1:0] cfg_mask_i,
  expander_if.slave     sti,
  expander_if.master    sto,
  output logic [0:0]    dbg_state_o
);
  localparam int DL = dl_of(DW);
  localparam logic [0:0] S_CFG = CFG;
  localparam logic [0:0] S_RUN = RUN;

  logic [0:0]           state_q, state_d;
  logic [DW-1:0]        mask_q;
  logic [DL-1:0]        dist_q [DW];
  logic [DL-1:0]        dist_d [DW];
  logic [DL:0]          zero_cnt;
  logic                 flush;
  logic                 adv;
  logic                 run_ready;
  logic [DL:0]          lay_valid;
  logic [DL:0][DW-1:0]  lay_data;

  always_comb begin
    state_d = state_q;
    if (ctl_clr_i) state_d = S_CFG;
    else if (state_q == S_CFG) state_d = S_RUN;
  end

  // Distance of bit k = zeros in mask below k; non-decreasing in k.
  always_comb begin
    zero_cnt = '0;
    for (int k = 0; k < DW; k++) begin
      dist_d[k] = zero_cnt[DL-1:0];
      zero_cnt  = zero_cnt + {{DL{1'b0}}, ~cfg_mask_i[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CFG;
      mask_q  <= '0;
      for (int k = 0; k < DW; k++) dist_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CFG) begin
        mask_q <= cfg_mask_i;
        for (int k = 0; k < DW; k++) dist_q[k] <= dist_d[k];
      end
    end
  end

  assign flush     = rst | ctl_clr_i;
  assign adv       = ctl_ena_i & (~lay_valid[DL] | sto.ready);
  assign run_ready = adv & (state_q == S_RUN) & ~flush;

  assign lay_valid[0] = sti.valid & run_ready;
  assign lay_data[0]  = sti.data;

  // Largest shift first keeps non-decreasing distances collision-free.
  for (genvar i = 0; i < DL; i++) begin : g_layer
    logic [DW-1:0] sel;

    always_comb begin
      for (int k = 0; k < DW; k++) sel[k] = dist_q[k][DL-1-i];
    end

    expander_layer #(
      .DW   (DW),
      .SHIFT(2 ** (DL - 1 - i))
    ) u_layer (
      .clk    (clk),
      .clr_i  (flush),
      .adv_i  (adv),
      .data_i (lay_data[i]),
      .valid_i(lay_valid[i]),
      .sel_i  (sel),
      .data_o (lay_data[i+1]),
      .valid_o(lay_valid[i+1])
    );
  end

  assign sti.ready   = ctl_ena_i ? run_ready : sto.ready;
  assign sto.valid   = ctl_ena_i ? lay_valid[DL] : sti.valid;
  assign sto.data    = ctl_ena_i ? (lay_data[DL] & mask_q) : sti.data;
  assign dbg_state_o = state_q;
endmodule
